// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_pkg
// Description : Shared types and constants for the instruction fetch front end:
//               fetch FSM state encoding, decode-buffer entry layout, reset PC
//               default and the sequential PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // one cycle after reset release
        REQ  = 2'd1,   // may present a request to instruction memory
        WAIT = 2'd2,   // one request outstanding, response will be kept
        DROP = 2'd3    // one request outstanding, response is wrong-path
    } fetch_state_e;

    // One decode-buffer entry
    typedef struct packed {
        logic [31:0]            pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Sequential next PC; the 32-bit add wraps 32'hFFFF_FFFC to 0 naturally
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Small {pc, instr} FIFO between fetch and decode. Flush has
//               priority over push/pop; simultaneous push and pop are allowed
//               at any occupancy. The head entry is read straight out of the
//               storage array, so it is stable until popped. The pointer
//               arithmetic is written for any depth, but the fetch unit only
//               uses (and is only qualified with) a depth of 2.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_flush,
    input  logic                           i_push,
    input  logic [31:0]                    i_push_pc,
    input  logic [INSTR_WIDTH-1:0]         i_push_instr,
    input  logic                           i_pop,
    output logic                           o_valid,
    output logic [31:0]                    o_pc,
    output logic [INSTR_WIDTH-1:0]         o_instr,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy; flush empties the FIFO without touching data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr].pc    <= i_push_pc;
                r_mem[r_wr_ptr].instr <= i_push_instr;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_pc    = r_mem[r_rd_ptr].pc;
    assign o_instr = r_mem[r_rd_ptr].instr;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Owns the architectural PC, issues instruction-memory requests
//               over a valid/ready port (at most one outstanding), accepts
//               redirects from execute (flushing wrong-path work) and feeds
//               decode through a 2-entry buffer.
//               Optional feature: define FETCH_MISALIGN_CHECK_EN to flag a
//               redirect to a non word-aligned PC on fetch_misalign (sticky)
//               and stop issuing requests. Without it redirect_pc[1:0] is
//               ignored and fetch_misalign is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [31:0]            imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [31:0]            if_pc,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic                   fetch_misalign
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e       r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;

    logic [CNT_W-1:0]   w_buf_count;
    logic [CNT_W:0]     w_occupancy;
    logic               w_outstanding;
    logic               w_slot_free;
    logic               w_issue_ok;
    logic               w_req_fire;
    logic               w_rsp_pending;
    logic               w_push;
    logic               w_pop;
    logic               w_buf_valid;
    logic [31:0]        w_redirect_target;

    // A request reserves a buffer slot when issued, so the buffer cannot overflow
    assign w_outstanding  = (r_state == WAIT) || (r_state == DROP);
    assign w_occupancy    = {1'b0, w_buf_count} + (CNT_W+1)'(w_outstanding);
    assign w_slot_free    = (w_occupancy < (CNT_W+1)'(BUF_DEPTH));

    // Redirect suppresses any request in its own cycle; address is the PC,
    // which only moves on accept or redirect, so it is stable under stall
    assign imem_req_valid = (r_state == REQ) && w_slot_free && !redirect_valid && w_issue_ok;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Response still owed after this cycle (decides DROP vs REQ on redirect)
    assign w_rsp_pending  = w_outstanding && !imem_rsp_valid;

    // Decode-buffer traffic; a redirect flushes and ignores push/pop that cycle
    assign w_push         = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_pop          = w_buf_valid && if_ready && !redirect_valid;
    assign if_valid       = w_buf_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    // Sticky misaligned-redirect flag; blocks all further requests until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign w_issue_ok        = !r_misalign;
    assign w_redirect_target = redirect_pc;
    assign fetch_misalign    = r_misalign;
`else
    logic w_unused_pc_lsbs;

    assign w_unused_pc_lsbs  = ^redirect_pc[1:0];
    assign w_issue_ok        = 1'b1;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign fetch_misalign    = 1'b0;
`endif

    // Fetch sequencer, PC and in-flight request PC; redirect beats every other event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (redirect_valid) begin
            r_pc    <= w_redirect_target;
            r_state <= w_rsp_pending ? DROP : REQ;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                end
                REQ: begin
                    if (w_req_fire) begin
                        r_req_pc <= r_pc;
                        r_pc     <= next_pc(r_pc);
                        r_state  <= WAIT;
                    end
                end
                WAIT, DROP: begin
                    if (imem_rsp_valid) begin
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH        (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (redirect_valid),
        .i_push       (w_push),
        .i_push_pc    (r_req_pc),
        .i_push_instr (imem_rsp_data),
        .i_pop        (w_pop),
        .o_valid      (w_buf_valid),
        .o_pc         (if_pc),
        .o_instr      (if_instr),
        .o_count      (w_buf_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural model keeps
//               the expected decode queue as a list of PCs, the expected next
//               request address, and a one-deep memory with configurable
//               latency. Directed scenarios are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import core_pkg::*;

    localparam logic [31:0] RST_PC = RESET_PC_DEFAULT;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misalign;

    fetch_unit #(
        .RESET_PC       (RST_PC),
        .BUF_DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;

    // reference model state
    logic [31:0] bufq [$];
    bit          mem_busy;
    bit          mem_drop;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          lat_max;
    bit          lat_rand;
    bit          rand_ready;
    logic [31:0] exp_req_pc;
    bit          m_mis;
    bit          m_idle;

    // observation logs and per-cycle samples
    logic [31:0] req_log [$];
    logic [31:0] dec_log [$];
    bit          s_req_valid;
    bit          s_fire;
    bit          s_rsp;
    logic [31:0] s_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
        return p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b0;
        bufq.delete();
        req_log.delete();
        dec_log.delete();
        mem_busy   = 1'b0;
        mem_drop   = 1'b0;
        mem_wait   = 0;
        exp_req_pc = RST_PC;
        m_mis      = 1'b0;
        m_idle     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 32'd0);
        chk("rst_req_addr",  imem_req_addr,  RST_PC);
        chk("rst_if_valid",  if_valid,       32'd0);
        chk("rst_if_pc",     if_pc,          32'd0);
        chk("rst_if_instr",  if_instr,       32'd0);
        chk("rst_misalign",  fetch_misalign, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model
    task automatic tick(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit m_pop;
        bit exp_v;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        imem_req_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        imem_rsp_valid = mem_busy && (mem_wait == 0);
        imem_rsp_data  = imem_rsp_valid ? instr_of(mem_addr) : $urandom();
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_fire      = imem_req_valid && imem_req_ready;
        s_rsp       = imem_rsp_valid;
        exp_v       = !m_idle && !mem_busy && (bufq.size() < 2) && !rv && !m_mis;
        m_pop       = (bufq.size() != 0) && rdy && !rv;
        chk("req_valid", s_req_valid, exp_v);
        chk("req_addr",  imem_req_addr, exp_req_pc);
        chk("if_valid",  if_valid, (bufq.size() != 0));
        if (bufq.size() != 0) begin
            chk("if_pc",    if_pc,    bufq[0]);
            chk("if_instr", if_instr, instr_of(bufq[0]));
        end
        chk("misalign", fetch_misalign, m_mis);
        if (s_fire) req_log.push_back(s_addr);
        if (m_pop)  dec_log.push_back(if_pc);
        @(posedge clk);
        if (rv) begin
            bufq.delete();
            exp_req_pc = tgt(rpc);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
`endif
            if (mem_busy && !s_rsp) mem_drop = 1'b1;
        end else begin
            if (m_pop) void'(bufq.pop_front());
            if (s_rsp && !mem_drop) bufq.push_back(mem_addr);
            if (s_fire) exp_req_pc = exp_req_pc + 32'd4;
        end
        if (s_rsp) begin
            mem_busy = 1'b0;
            mem_drop = 1'b0;
        end else if (mem_busy && mem_wait > 0) begin
            mem_wait--;
        end
        if (s_fire) begin
            mem_busy = 1'b1;
            mem_drop = 1'b0;
            mem_addr = s_addr;
            mem_wait = lat_rand ? int'($urandom_range(lat_max - 1, 0)) : lat_max - 1;
        end
        m_idle = 1'b0;
    endtask

    task automatic run_until_req(input logic [31:0] a, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b0, '0, 1'b1);
            if (s_fire && s_addr == a) found = 1'b1;
        end
    endtask

    initial begin
        bit          found;
        bit          rv;
        logic [31:0] rpc;
        n_checks   = 0;
        n_fail     = 0;
        lat_max    = 1;
        lat_rand   = 1'b0;
        rand_ready = 1'b0;

        // Streaming with always-ready memory and decode
        do_reset();
        repeat (10) tick(1'b0, '0, 1'b1);
        chk("t1_req_cnt", (req_log.size() >= 3), 32'd1);
        chk("t1_req0", q_at(req_log, 0), 32'h0);
        chk("t1_req1", q_at(req_log, 1), 32'h4);
        chk("t1_req2", q_at(req_log, 2), 32'h8);
        chk("t1_dec0", q_at(dec_log, 0), 32'h0);
        chk("t1_dec1", q_at(dec_log, 1), 32'h4);

        // Decode stalled: buffer fills to two, then drains in order
        do_reset();
        repeat (10) tick(1'b0, '0, 1'b0);
        chk("t2_req_cnt",  req_log.size(), 32'd2);
        chk("t2_no_req",   s_req_valid,    32'd0);
        chk("t2_if_valid", if_valid,       32'd1);
        chk("t2_if_pc",    if_pc,          32'h0);
        repeat (12) tick(1'b0, '0, 1'b1);
        chk("t2_dec_cnt", (dec_log.size() >= 3), 32'd1);
        for (int i = 0; i < dec_log.size(); i++) begin
            chk("t2_dec_seq", dec_log[i], 32'(4 * i));
        end

        // Redirect while 0x8 is outstanding (2-cycle memory)
        do_reset();
        lat_max = 2;
        run_until_req(32'h8, found);
        chk("t3_found", found, 32'd1);
        tick(1'b1, 32'h100, 1'b1);
        chk("t3_rsp_pending", s_rsp, 32'd0);
        req_log.delete();
        dec_log.delete();
        repeat (12) tick(1'b0, '0, 1'b1);
        chk("t3_req0", q_at(req_log, 0), 32'h100);
        chk("t3_dec0", q_at(dec_log, 0), 32'h100);
        chk("t3_dec1", q_at(dec_log, 1), 32'h104);

        // Redirect in the same cycle as the response
        do_reset();
        lat_max = 1;
        run_until_req(32'h8, found);
        chk("t4_found", found, 32'd1);
        tick(1'b1, 32'h100, 1'b1);
        chk("t4_rsp_same", s_rsp,       32'd1);
        chk("t4_no_req",   s_req_valid, 32'd0);
        req_log.delete();
        dec_log.delete();
        repeat (8) tick(1'b0, '0, 1'b1);
        chk("t4_req0", q_at(req_log, 0), 32'h100);
        chk("t4_dec0", q_at(dec_log, 0), 32'h100);

        // PC wrap at the top of the address space
        do_reset();
        tick(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (10) tick(1'b0, '0, 1'b1);
        chk("t5_req0", q_at(req_log, 0), 32'hFFFF_FFFC);
        chk("t5_req1", q_at(req_log, 1), 32'h0000_0000);
        chk("t5_dec0", q_at(dec_log, 0), 32'hFFFF_FFFC);
        chk("t5_dec1", q_at(dec_log, 1), 32'h0000_0000);

        // Misaligned redirect
        do_reset();
        tick(1'b0, '0, 1'b1);
        tick(1'b1, 32'h102, 1'b1);
        req_log.delete();
        repeat (6) tick(1'b0, '0, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("t6_misalign", fetch_misalign, 32'd1);
        chk("t6_no_req",   req_log.size(), 32'd0);
`else
        chk("t6_misalign", fetch_misalign, 32'd0);
        chk("t6_req0",     q_at(req_log, 0), 32'h100);
`endif

        // Randomized traffic: memory back-pressure, latency 1..3, redirects
        do_reset();
        rand_ready = 1'b1;
        lat_rand   = 1'b1;
        lat_max    = 3;
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(15, 0) == 0);
            if ($urandom_range(3, 0) == 0) begin
                rpc = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(3, 0)), 2'b00};
            end else begin
                rpc = $urandom() & 32'hFFFF_FFFC;
            end
            tick(rv, rpc, ($urandom_range(3, 0) != 0));
        end
        chk("t7_progress", (dec_log.size() > 20), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
